// File: rtl/seg_pkg.sv
// Shared constants and types for the 4-digit 7-segment scan controller.
// Latency: none (declarations only).
// Backpressure: not applicable.
package seg_pkg;

  localparam logic [6:0] SEG_OFF    = 7'h7F;
  localparam logic [3:0] ANODE_OFF  = 4'hF;
  localparam int         SLOT_TICKS = 16;

  typedef enum logic {
    ST_BLANK,
    ST_ON
  } state_t;

  // Active-low patterns, bit order {g,f,e,d,c,b,a}; index 15 is leftmost.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,  // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,  // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,  // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40   // 3 2 1 0
  };

endpackage

// File: rtl/seg_hex_decode.sv
// Nibble to active-low 7-segment pattern decoder.
// Latency: combinational.
// Backpressure: not applicable.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Table lookup of the hex glyph for the selected nibble.
  always_comb begin
    seg = SEG_TABLE[nibble];
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Scan scheduler for a 4-digit multiplexed 7-segment display with PWM brightness.
// Latency: pins lag the scan state by one i_clk; shadow load applies at the next frame boundary.
// Backpressure: none; repeated loads while pending overwrite the shadow. Optional SEG_LZB_EN adds leading-zero blanking.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int TICK_DIV = 1000,
  parameter int DIGITS   = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_value,
  input  logic [3:0]  i_dp,
  input  logic [3:0]  i_digit_en,
  input  logic        i_load,
  input  logic [3:0]  i_bright,
  output logic        o_ack,
  output logic        o_frame,
  output logic [1:0]  o_digit,
  output logic [3:0]  o_anode,
  output logic [6:0]  o_seg,
  output logic        o_dp
);

  localparam logic [15:0] TICK_MAX  = 16'(TICK_DIV - 1);
  localparam logic [3:0]  SLOT_LAST = 4'(SLOT_TICKS - 1);
  localparam logic [1:0]  DIG_LAST  = 2'(DIGITS - 1);

  logic [15:0] presc;
  logic [3:0]  slot_cnt;
  logic [1:0]  digit;
  state_t      state, state_nxt;

  logic [15:0] active_val, shadow_val;
  logic [3:0]  active_dp, shadow_dp;
  logic        pending;

  logic        tick, slot_end, boundary;
  logic [3:0]  cur_nib;
  logic        cur_dp;
  logic [6:0]  dec_seg;
  logic        lit;
  logic        lzb_blank;

  logic [3:0]  anode_nxt;
  logic [6:0]  seg_nxt;
  logic        dp_nxt;

  assign tick     = (presc == TICK_MAX);
  assign slot_end = tick && (slot_cnt == SLOT_LAST);
  assign boundary = slot_end && (digit == DIG_LAST);
  assign o_digit  = digit;

  // Prescaler: one scan tick every TICK_DIV cycles.
  always_ff @(posedge i_clk) begin
    if (i_rst)     presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + 16'd1;
  end

  // Slot counter and digit index; the digit advances when a slot finishes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      slot_cnt <= '0;
      digit    <= '0;
    end else if (tick) begin
      slot_cnt <= slot_cnt + 4'd1;
      if (slot_end) digit <= digit + 2'd1;
    end
  end

  // Scan state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_BLANK;
    else       state <= state_nxt;
  end

  // Next state: one blanking tick, then fifteen PWM ticks per slot.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_BLANK: if (tick)     state_nxt = ST_ON;
      ST_ON:    if (slot_end) state_nxt = ST_BLANK;
      default:                state_nxt = ST_BLANK;
    endcase
  end

  // Shadow/active registers: copy at the frame boundary, a same-cycle load refills the shadow.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      shadow_val <= '0;
      shadow_dp  <= '0;
      active_val <= '0;
      active_dp  <= '0;
      pending    <= 1'b0;
      o_ack      <= 1'b0;
      o_frame    <= 1'b0;
    end else begin
      o_frame <= boundary;
      o_ack   <= boundary && pending;
      if (boundary && pending) begin
        active_val <= shadow_val;
        active_dp  <= shadow_dp;
        pending    <= 1'b0;
      end
      if (i_load) begin
        shadow_val <= i_value;
        shadow_dp  <= i_dp;
        pending    <= 1'b1;
      end
    end
  end

  // Select the nibble and decimal point of the digit being scanned.
  always_comb begin
    cur_nib = active_val[{digit, 2'b00} +: 4];
    cur_dp  = active_dp[digit];
  end

  seg_hex_decode u_dec (
    .nibble (cur_nib),
    .seg    (dec_seg)
  );

`ifdef SEG_LZB_EN
  // Leading zeros are suppressed from the left; digit 0 always shows.
  always_comb begin
    lzb_blank = 1'b0;
    case (digit)
      2'd3:    lzb_blank = (active_val[15:12] == 4'h0);
      2'd2:    lzb_blank = (active_val[15:8]  == 8'h00);
      2'd1:    lzb_blank = (active_val[15:4]  == 12'h000);
      default: lzb_blank = 1'b0;
    endcase
  end
`else
  // Without blanking every enabled digit shows its value.
  always_comb begin
    lzb_blank = 1'b0;
  end
`endif

  // Pin values: lit while in the PWM window of an enabled digit, dark otherwise.
  always_comb begin
    anode_nxt = ANODE_OFF;
    seg_nxt   = SEG_OFF;
    dp_nxt    = 1'b1;
    lit       = (state == ST_ON) && i_digit_en[digit] && (slot_cnt <= i_bright);
    if (lit) begin
      if (!lzb_blank) begin
        anode_nxt[digit] = 1'b0;
        seg_nxt          = dec_seg;
        dp_nxt           = ~cur_dp;
      end else if (cur_dp) begin
        anode_nxt[digit] = 1'b0;
        dp_nxt           = 1'b0;
      end
    end
  end

  // Registered pins so the drivers see glitch-free levels.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_anode <= ANODE_OFF;
      o_seg   <= SEG_OFF;
      o_dp    <= 1'b1;
    end else begin
      o_anode <= anode_nxt;
      o_seg   <= seg_nxt;
      o_dp    <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with TICK_DIV=4 (64-cycle slots, 256-cycle frames).
// Offsets k below count negedges after the sample where o_frame is seen high.
// Honours SEG_LZB_EN for the leading-zero checks.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  digit_en;
  logic        load;
  logic [3:0]  bright;
  logic        ack, frame;
  logic [1:0]  digit;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        dp_pin;

  int n_assert = 0;
  int n_fail   = 0;
  int cur      = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.TICK_DIV(4), .DIGITS(4)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_value    (value),
    .i_dp       (dp),
    .i_digit_en (digit_en),
    .i_load     (load),
    .i_bright   (bright),
    .o_ack      (ack),
    .o_frame    (frame),
    .o_digit    (digit),
    .o_anode    (anode),
    .o_seg      (seg),
    .o_dp       (dp_pin)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic at(input int k);
    while (cur < k) begin
      @(negedge clk);
      cur++;
    end
  endtask

  task automatic wait_frame();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame !== 1'b1 && n < 600);
    chk("frame_seen", {15'd0, frame}, 16'd1);
    cur = 0;
  endtask

  task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp    = d;
    load  = 1'b1;
    @(negedge clk);
    cur++;
    load  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; value = '0; dp = '0; digit_en = 4'hF; load = 1'b0; bright = 4'hF;
    repeat (3) @(negedge clk);
    chk("rst_anode", {12'd0, anode}, 16'hF);
    chk("rst_seg",   {9'd0, seg},    16'h7F);
    chk("rst_dp",    {15'd0, dp_pin}, 16'd1);
    chk("rst_digit", {14'd0, digit}, 16'd0);
    chk("rst_ack",   {15'd0, ack},   16'd0);
    chk("rst_frame", {15'd0, frame}, 16'd0);
    rst = 1'b0;

    // Load 1234 right after reset; it lands at the first boundary.
    pulse_load(16'h1234, 4'b0100);
    wait_frame();
    chk("f1_ack", {15'd0, ack}, 16'd1);
    at(1);   chk("f1_ack_off", {15'd0, ack}, 16'd0);
             chk("f1_frame_off", {15'd0, frame}, 16'd0);
    at(4);   chk("blank_end", {12'd0, anode}, 16'hF);
             chk("blank_seg", {9'd0, seg}, 16'h7F);
    at(5);   chk("d0_first", {12'd0, anode}, 16'hE);
    at(10);  chk("d0_seg", {9'd0, seg}, 16'h19);
             chk("d0_dp", {15'd0, dp_pin}, 16'd1);
             chk("d0_digit", {14'd0, digit}, 16'd0);
    at(64);  chk("d0_last", {12'd0, anode}, 16'hE);
    at(65);  chk("d1_blank", {12'd0, anode}, 16'hF);
    at(70);  chk("d1_anode", {12'd0, anode}, 16'hD);
             chk("d1_seg", {9'd0, seg}, 16'h30);
             chk("d1_digit", {14'd0, digit}, 16'd1);
    at(134); chk("d2_anode", {12'd0, anode}, 16'hB);
             chk("d2_seg", {9'd0, seg}, 16'h24);
             chk("d2_dp", {15'd0, dp_pin}, 16'd0);
    at(198); chk("d3_anode", {12'd0, anode}, 16'h7);
             chk("d3_seg", {9'd0, seg}, 16'h79);

    // Mid-frame load must not tear the current frame.
    at(200); pulse_load(16'hABCD, 4'b0000);
    at(220); chk("hold_seg", {9'd0, seg}, 16'h79);
    wait_frame();
    chk("abcd_ack", {15'd0, ack}, 16'd1);
    at(10);  chk("abcd_d0", {9'd0, seg}, 16'h21);
    at(70);  chk("abcd_d1", {9'd0, seg}, 16'h46);
    at(134); chk("abcd_d2", {9'd0, seg}, 16'h03);
             chk("abcd_dp2", {15'd0, dp_pin}, 16'd1);
    at(198); chk("abcd_d3", {9'd0, seg}, 16'h08);

    // No pending load: frame pulses alone. Then brightness 3.
    wait_frame();
    chk("noack", {15'd0, ack}, 16'd0);
    bright = 4'd3;
    at(5);   chk("b3_on_first", {12'd0, anode}, 16'hE);
    at(16);  chk("b3_on_last", {12'd0, anode}, 16'hE);
    at(17);  chk("b3_off", {12'd0, anode}, 16'hF);
    at(80);  chk("b3_d1_last", {12'd0, anode}, 16'hD);
    at(81);  chk("b3_d1_off", {12'd0, anode}, 16'hF);

    wait_frame();
    bright = 4'd0;
    at(10);  chk("b0_d0", {12'd0, anode}, 16'hF);
    at(70);  chk("b0_d1", {12'd0, anode}, 16'hF);
    at(198); chk("b0_d3", {12'd0, anode}, 16'hF);

    wait_frame();
    bright = 4'hF;
    digit_en = 4'b1101;
    at(10);  chk("en_d0", {12'd0, anode}, 16'hE);
    at(70);  chk("en_d1_off", {12'd0, anode}, 16'hF);
             chk("en_d1_seg", {9'd0, seg}, 16'h7F);
    at(134); chk("en_d2", {12'd0, anode}, 16'hB);
    digit_en = 4'hF;

    // Two loads then a load on the boundary cycle.
    wait_frame();
    at(20);  pulse_load(16'h5678, 4'b0000);
    at(30);  pulse_load(16'h9ABC, 4'b0000);
    at(100); chk("multi_noack", {15'd0, ack}, 16'd0);
    at(255);
    value = 16'h0F0F; load = 1'b1;
    @(negedge clk);
    load = 1'b0; cur = 0;
    chk("bnd_frame", {15'd0, frame}, 16'd1);
    chk("bnd_ack", {15'd0, ack}, 16'd1);
    at(1);   chk("bnd_ack_once", {15'd0, ack}, 16'd0);
    at(10);  chk("v2_d0", {9'd0, seg}, 16'h46);
    at(198); chk("v2_d3", {9'd0, seg}, 16'h10);
    wait_frame();
    chk("v3_ack", {15'd0, ack}, 16'd1);
    at(10);  chk("v3_d0", {9'd0, seg}, 16'h0E);
    at(70);  chk("v3_d1", {9'd0, seg}, 16'h40);

    // Reset during digit 2 with a load pending.
    at(130); pulse_load(16'h4321, 4'b0000);
    at(140); chk("pre_rst_anode", {12'd0, anode}, 16'hB);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_anode", {12'd0, anode}, 16'hF);
    chk("mrst_seg", {9'd0, seg}, 16'h7F);
    chk("mrst_digit", {14'd0, digit}, 16'd0);
    rst = 1'b0;
    wait_frame();
    chk("mrst_noack", {15'd0, ack}, 16'd0);
    at(10);  chk("mrst_active0", {9'd0, seg}, 16'h40);
             chk("mrst_d0", {12'd0, anode}, 16'hE);

    // Leading-zero value.
    pulse_load(16'h0050, 4'b0000);
    wait_frame();
    chk("lz_ack", {15'd0, ack}, 16'd1);
    at(10);  chk("lz_d0", {9'd0, seg}, 16'h40);
             chk("lz_d0_an", {12'd0, anode}, 16'hE);
    at(70);  chk("lz_d1", {9'd0, seg}, 16'h12);
             chk("lz_d1_an", {12'd0, anode}, 16'hD);
`ifdef SEG_LZB_EN
    at(134); chk("lz_d2_an", {12'd0, anode}, 16'hF);
    at(198); chk("lz_d3_an", {12'd0, anode}, 16'hF);
             chk("lz_d3_seg", {9'd0, seg}, 16'h7F);
`else
    at(134); chk("lz_d2_an", {12'd0, anode}, 16'hB);
             chk("lz_d2_seg", {9'd0, seg}, 16'h40);
    at(198); chk("lz_d3_an", {12'd0, anode}, 16'h7);
             chk("lz_d3_seg", {9'd0, seg}, 16'h40);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Scan scheduler for the 4-digit multiplexed 7-segment display.
- Holds a 4-nibble display value and loads new values through a shadow register, applied only at frame boundaries so digits never tear.
- Time-slices the common anodes and inserts a blanking tick between digits to stop ghosting.
- Applies 16-level PWM brightness and drives active-low anode, segment and decimal-point pins directly.

Parameters:
TICK_DIV, 1000, i_clk cycles per scan tick; legal range 2..65535.
DIGITS, 4, number of digits; fixed at 4 in this revision.

Ports:
i_clk  input  1  system clock.
i_rst  input  1  reset: synchronous, active-high (clock i_clk).
i_value  input  16  display value; nibble k shown on digit k; digit 0 is rightmost.
i_dp  input  4  decimal point per digit, active-high.
i_digit_en  input  4  per-digit enable; a disabled digit stays dark for its whole slot.
i_load  input  1  one-cycle strobe; captures i_value and i_dp into the shadow register.
i_bright  input  4  lit ticks per slot, 0..15; 0 means dark.
o_ack  output  1  one-cycle pulse when the shadow is copied to the active register.
o_frame  output  1  one-cycle pulse at the end of the digit-3 slot.
o_digit  output  2  index of the current slot.
o_anode  output  4  active-low anode select; digit k drives bit k low.
o_seg  output  7  active-low segments, bit order {g,f,e,d,c,b,a}.
o_dp  output  1  active-low decimal point.

Behaviour:
- Reset values: o_anode=4'b1111, o_seg=7'h7F, o_dp=1, o_digit=0, o_ack=0, o_frame=0.
- Reset also clears: active and shadow registers to 0, pending flag to 0, prescaler to 0, slot counter to 0, state to BLANK.
- Reset mid-frame aborts the slot immediately. The first slot after reset is digit 0.
- Prescaler: counts 0..TICK_DIV-1. A tick fires on the cycle the count is TICK_DIV-1, then the count wraps to 0.
- Slot timing: each slot is 16 ticks. slot_cnt runs 0..15 and advances on each tick.
- State BLANK (slot_cnt=0): all anodes off, o_seg=7'h7F.
  - Goes to ON on the tick that ends slot_cnt 0.
- State ON (slot_cnt=1..15): digit d is lit when i_digit_en[d]=1 and slot_cnt <= i_bright.
  - Lit means o_anode bit d low, o_seg = decoded nibble d, o_dp = ~dp[d].
  - Otherwise the outputs are dark, as in BLANK.
  - On the tick that ends slot_cnt 15: o_digit advances with wrap 3->0, and the state returns to BLANK.
- i_bright is sampled every cycle, so a change takes effect within the current slot.
- Outputs are registered: pins follow state and slot_cnt with one i_clk cycle of latency.
- Load handshake:
  - i_load=1 writes i_value and i_dp into the shadow and sets pending.
  - A repeated load while pending overwrites the shadow; only one o_ack results.
- Frame boundary (the tick ending the digit-3 slot):
  - o_frame pulses for that one cycle.
  - If pending=1: the shadow is copied to active, o_ack pulses in the same cycle, and pending clears.
- i_load on the boundary cycle: the copy uses the shadow as it was before that cycle. The new data enters the shadow, pending stays 1, and the new data is applied at the next boundary.
- Decode (active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex).

Optional Feature:
SEG_LZB_EN: leading-zero blanking.
- Defined:
  - Digit 3 is dark if active nibble 3 = 0.
  - Digit 2 is dark if nibbles 3 and 2 are both 0.
  - Digit 1 is dark if nibbles 3, 2 and 1 are all 0.
  - Digit 0 is never blanked.
  - A blanked digit still shows its decimal point if dp=1, with the anode asserted.
- Undefined: all enabled digits always display their value.

Decomposition:
- Package seg_pkg holds:
  - SEG_OFF=7'h7F, ANODE_OFF=4'hF.
  - SLOT_TICKS=16.
  - State enum {ST_BLANK, ST_ON}.
  - The 16-entry segment pattern constants.
- Sub-module seg_hex_decode: combinational 4-bit nibble to 7-bit active-low pattern, instantiated once on the selected nibble.

Test Plan:
- Reset then run, TICK_DIV=4, i_bright=15, all digits enabled, load 16'h1234:
  - Anodes step 1110 -> 1101 -> 1011 -> 0111, each low for 60 cycles after a 4-cycle all-high blank.
  - o_seg = 19 / 30 / 24 / 79 (hex) for digits 0..3.
- Load 16'hABCD mid-frame:
  - Display stays 1234 until the boundary.
  - o_ack and o_frame pulse on the same cycle; the next frame shows ABCD.
- i_bright=3:
  - Digit lit for 12 cycles (slot_cnt 1..3), then dark for 48 cycles.
- i_bright=0:
  - o_anode stays 1111 throughout.
- Two loads 10 cycles apart, then a load on the boundary cycle:
  - Exactly one o_ack at the first boundary, showing the second value.
  - The third value appears one frame later with a second o_ack.
- i_rst asserted mid-slot of digit 2:
  - Next cycle o_anode=1111, o_seg=7F, o_digit=0, pending cleared.
- With SEG_LZB_EN, value 16'h0050:
  - Digits 3 and 2 dark; digit 1 shows 12 (hex, pattern for 5); digit 0 shows 40 (hex, pattern for 0).
